// File: rtl/v_tag_acc_pkg.sv
// Shared definitions for the v_tag_acc tag accumulator: GF(2^32) reduction
// constant, row counts, FSM state type and the single multiply-by-alpha step.
package v_tag_pkg;

  localparam logic [31:0] CONST_ALPHA_32 = 32'h0040_0007;
  localparam int          NROWS_AD       = 5;
  localparam int          NROWS_MSG      = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ABSORB = 2'd1,
    DONE   = 2'd2
  } state_e;

  // Multiply by alpha in GF(2^32): shift left, fold the carried-out bit back
  // in through the reduction polynomial.
  function automatic logic [31:0] gf32_xalpha(input logic [31:0] x);
    logic [31:0] r;
    r = {x[30:0], 1'b0};
    if (x[31]) begin
      r = r ^ CONST_ALPHA_32;
    end else begin
      r = r;
    end
    return r;
  endfunction

endpackage

// File: rtl/v_tag_acc_if.sv
// PDP word stream and finished-tag stream of the tag accumulator.
// master: producer/consumer side; slave: the accumulator.
interface v_tag_acc_if;

  logic         pdp_valid;
  logic [31:0]  pdp_data;
  logic         pdp_last;
  logic         pdp_ready;
  logic         tag_valid;
  logic [159:0] tag_out;
  logic         tag_ready;

  modport master (
    output pdp_valid, pdp_data, pdp_last, tag_ready,
    input  pdp_ready, tag_valid, tag_out
  );

  modport slave (
    input  pdp_valid, pdp_data, pdp_last, tag_ready,
    output pdp_ready, tag_valid, tag_out
  );

endinterface

// File: rtl/v_tag_acc_gf32_mul_alpha_pow.sv
// Combinational multiply by alpha^POW in GF(2^32), built as POW chained
// multiply-by-alpha steps.
module gf32_mul_alpha_pow
  import v_tag_pkg::*;
#(
  parameter int POW = 1
) (
  input  logic [31:0] x_i,
  output logic [31:0] y_o
);

  logic [31:0] acc_s;

  // Apply the single alpha step POW times.
  always_comb begin
    acc_s = x_i;
    for (int k = 0; k < POW; k++) begin
      acc_s = gf32_xalpha(acc_s);
    end
    y_o = acc_s;
  end

endmodule

// File: rtl/v_tag_acc.sv
// v_tag_acc: sequential Vandermonde/Horner tag accumulator.
// Row r is updated per accepted PDP word as row_r <= alpha^r * row_r ^ pdp.
// Optional feature macro: V_TAG_ACC_WCNT_EN adds a saturating word counter
// output word_cnt.
module v_tag_acc
  import v_tag_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           full,
  output logic           busy,
  v_tag_acc_if.slave     bus
`ifdef V_TAG_ACC_WCNT_EN
  ,
  output logic [CNT_W-1:0] word_cnt
`endif
);

  state_e                         state_q, state_d;
  logic                           full_q, full_d;
  logic [NROWS_AD-1:0][31:0]      row_q, row_d;
  logic [NROWS_AD-1:0][31:0]      row_mul_s;
  logic                           accept_s;

  // Row 0 is multiplied by alpha^0, so it bypasses the multiplier chain.
  assign row_mul_s[0] = row_q[0];

  for (genvar p = 1; p < NROWS_AD; p++) begin : g_mul
    gf32_mul_alpha_pow #(.POW(p)) u_mul (
      .x_i (row_q[p]),
      .y_o (row_mul_s[p])
    );
  end

  assign accept_s = bus.pdp_valid & (state_q == ABSORB);

  // Outputs depend only on registered state, never on inputs.
  assign bus.pdp_ready = (state_q == ABSORB);
  assign bus.tag_valid = (state_q == DONE);
  assign busy          = (state_q != IDLE);
  assign bus.tag_out   = row_q;

  // Next-state, row update and mode latch.
  always_comb begin
    state_d = state_q;
    full_d  = full_q;
    row_d   = row_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          row_d   = '0;
          full_d  = full;
          state_d = ABSORB;
        end else begin
          state_d = IDLE;
        end
      end
      ABSORB: begin
        if (accept_s) begin
          for (int r = 0; r < NROWS_MSG; r++) begin
            row_d[r] = row_mul_s[r] ^ bus.pdp_data;
          end
          if (full_q) begin
            row_d[NROWS_AD-1] = row_mul_s[NROWS_AD-1] ^ bus.pdp_data;
          end else begin
            row_d[NROWS_AD-1] = 32'h0000_0000;
          end
          if (bus.pdp_last) begin
            state_d = DONE;
          end else begin
            state_d = ABSORB;
          end
        end else begin
          state_d = ABSORB;
        end
      end
      DONE: begin
        if (bus.tag_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, mode and tag registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      full_q  <= 1'b0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      full_q  <= full_d;
      row_q   <= row_d;
    end
  end

`ifdef V_TAG_ACC_WCNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Word counter: cleared on start, saturating increment per accepted word.
  always_comb begin
    cnt_d = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q;
        end
      end
      ABSORB: begin
        if (accept_s && (cnt_q != {CNT_W{1'b1}})) begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        cnt_d = cnt_q;
      end
    endcase
  end

  // Word counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign word_cnt = cnt_q;
`endif

endmodule

// File: doc/v_tag_acc.md
Name: v_tag_acc

Overview:
- Sequential tag accumulator that drives the 32-bit Vandermonde Horner update.
- Accepts a stream of 32-bit PDP words over a valid/ready handshake and holds the running tag register.
- Per accepted word, applies one Horner step (row i multiplied by alpha^i in GF(2^32), then XOR PDP) and registers the result.
- Sits between the PDP producer and the top-level tag finaliser; delivers the finished 160-bit (AD) or 128-bit (message) tag.

Parameters:
- CONST_ALPHA_32, 32'h00400007, reduction polynomial for GF(2^32).
- CNT_W, 16, width of the optional word counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a new tag; sampled only in IDLE.
- full  in  1  sampled with start: 1 = AD mode (5 rows, 160 bits), 0 = message mode (4 rows, 128 bits).
- pdp_valid  in  1  pdp_data/pdp_last valid.
- pdp_data  in  32  PDP word.
- pdp_last  in  1  final word of this tag.
- pdp_ready  out  1  accumulator accepts a word.
- tag_valid  out  1  tag_out holds a finished tag.
- tag_out  out  160  row r occupies bits [32r+31:32r]; rows 4 read zero in message mode.
- tag_ready  in  1  consumer accepts tag_out.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (synchronous, active-high, one clk edge):
  - state = IDLE; tag register = 0; full_q = 0.
  - pdp_ready = 0, tag_valid = 0, busy = 0, tag_out = 0.
- IDLE:
  - pdp_ready = 0.
  - start = 1: clear tag register, latch full_q = full, go to ABSORB on the next cycle.
- ABSORB:
  - pdp_ready = 1.
  - Word accepted when pdp_valid & pdp_ready. On that edge:
    - row0 <= row0 ^ pdp
    - row1 <= alpha*row1 ^ pdp
    - row2 <= alpha^2*row2 ^ pdp
    - row3 <= alpha^3*row3 ^ pdp
    - row4 <= alpha^4*row4 ^ pdp, only if full_q; otherwise row4 held at 0.
  - alpha*x: {x[30:0],1'b0}, XORed with CONST_ALPHA_32 when x[31] = 1. alpha^k applies this k times.
  - Accepted word with pdp_last = 1: update applied, then go to DONE.
  - Latency: the tag is visible one cycle after the last accepted word.
- DONE:
  - tag_valid = 1; pdp_ready = 0.
  - tag_out is held stable until tag_ready = 1, then go to IDLE.
  - tag_out keeps its value in IDLE until the next start clears it.
- start outside IDLE is ignored.
- start and rst asserted together: rst wins.
- rst mid-ABSORB or mid-DONE: partial tag is discarded and all outputs return to reset values.
- Zero-word tag is not supported; at least one word with pdp_last is required.
- pdp_valid is ignored in IDLE and DONE. Upstream must hold pdp_data and pdp_last until the word is accepted.
- Combinational path from inputs to pdp_ready: none (pdp_ready is a function of state only).

Optional Feature:
- Macro: V_TAG_ACC_WCNT_EN.
- When defined:
  - Adds output word_cnt [CNT_W-1:0].
  - Cleared on rst and on accepted start; increments per accepted word; saturates at all-ones.
  - Held through DONE.
- When undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package v_tag_pkg holds:
  - CONST_ALPHA_32
  - NROWS_AD = 5, NROWS_MSG = 4
  - state typedef {IDLE, ABSORB, DONE}
  - function gf32_xalpha (single multiply-by-alpha step)
- One sub-module, gf32_mul_alpha_pow (parameter POW):
  - Purely combinational; chains POW gf32_xalpha steps.
  - Instantiated for POW = 1..4.
  - Row 0 needs no instance.

Test Plan:
- Message mode, single word: full=0, one word 0x00000001 with last -> tag_out[127:0] = 00000001_00000001_00000001_00000001, tag_out[159:128] = 0, tag_valid one cycle after acceptance.
- Two words, message mode: words 0x00000001 then 0x00000000 (last) -> rows {3..0} = 00000008, 00000004, 00000002, 00000001.
- Reduction wrap: words 0x80000000 then 0x00000000 (last), full=0 -> row0 = 80000000, row1 = 00400007, row2 = 0080000E, row3 = 0100001C.
- AD mode: full=1, words 0x00000001 then 0x00000000 (last) -> row4 = 00000010, rows 3..0 as in the two-word message case.
- Backpressure:
  - tag_ready held low 5 cycles -> tag_out stable, pdp_ready = 0 throughout.
  - start pulsed during DONE -> ignored.
  - tag_ready high -> IDLE next cycle.
- Reset mid-ABSORB after 2 words: all outputs 0. Next start with word 0x00000001 (last) gives the single-word result (no residue). With V_TAG_ACC_WCNT_EN defined, word_cnt = 1.
